// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one write/read port pair of the data RAM between two masters.
// One transaction in flight; reads wait a fixed RAM latency and return a one-cycle rvalid pulse.
module ram_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              busy,
    output logic              wea,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_dout
);

    // state | meaning
    // IDLE  | no transaction; arbitrate among incoming requests
    // ISSUE | grant pulse; write strobed into RAM or read address presented
    // WAIT  | read address held while the RAM latency elapses
    // RESP  | read data registered; rvalid pulse to the winner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

    state_t             state;
    logic               last;
    logic               win;
    logic               cur_we;
    logic [CNT_W-1:0]   cnt;

    logic               pick;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // On a tie the master that was not served last wins; last resets to m1 so m0 wins first.
    always_comb begin
        pick      = (m0_req && m1_req) ? ~last : m1_req;
        sel_we    = pick ? m1_we    : m0_we;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            cur_we    <= 1'b0;
            cnt       <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            busy      <= 1'b0;
            wea       <= 1'b0;
            ram_waddr <= '0;
            ram_din   <= '0;
            ram_raddr <= '0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            wea       <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        win    <= pick;
                        last   <= pick;
                        cur_we <= sel_we;
                        busy   <= 1'b1;
                        if (pick) m1_gnt <= 1'b1;
                        else      m0_gnt <= 1'b1;
                        if (sel_we) begin
                            wea       <= 1'b1;
                            ram_waddr <= sel_addr;
                            ram_din   <= sel_wdata;
                        end else begin
                            ram_raddr <= sel_addr;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (RD_LAT == 1) begin
                        if (win) begin
                            m1_rdata  <= ram_dout;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= ram_dout;
                            m0_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt   <= CNT_W'(RD_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Capture lands exactly RD_LAT edges after ISSUE was entered.
                    if (cnt == CNT_W'(1)) begin
                        if (win) begin
                            m1_rdata  <= ram_dout;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= ram_dout;
                            m0_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
